load_store_unit: RTL and testbench

//  Data-memory access stage downstream of the control unit. Consumes memRead/memWrite/memOffset/unsignedFlag,
//  the ALU address and rs2 data; runs a req/ack transaction to data memory; stalls the core until complete.

---
 rtl/load_store_unit.sv | 176 +++++++++++++++++
 tb/tb_load_store_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Function : Data-memory access stage. It issues one req/ack transaction per
//            load or store, builds byte enables and lane-replicated store data,
//            and extends load data. Optional macro MISALIGN_TRAP_EN traps
//            misaligned accesses.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              memRead,
   input  logic              memWrite,
   input  logic [2:0]        memOffset,
   input  logic              unsignedFlag,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              stall,
   output logic [DATA_W-1:0] rdata,
   output logic              done,
   output logic              misalign_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [1:0] c_SZ_BYTE = 2'd0;
   localparam logic [1:0] c_SZ_HALF = 2'd1;
   localparam logic [1:0] c_SZ_WORD = 2'd2;

   state_t            r_state;
   state_t            w_next;
   logic              w_start;
   logic              w_trap;
   logic [1:0]        w_size;
   logic [1:0]        w_lo;
   logic [3:0]        w_be;
   logic [DATA_W-1:0] w_wdata;
   logic [DATA_W-1:0] w_shift;
   logic [DATA_W-1:0] w_load;
   logic              r_read;
   logic              r_uns;
   logic [1:0]        r_size;
   logic [1:0]        r_lo;

   assign w_start = (r_state == S_IDLE) && (memRead || memWrite);
   assign stall   = !rst && (w_start || (r_state == S_REQ));
   assign done    = (r_state == S_DONE);

   always_comb begin
      w_size = c_SZ_WORD;
      if (memOffset == 3'b001)
         w_size = c_SZ_BYTE;
      else if (memOffset == 3'b010)
         w_size = c_SZ_HALF;
   end

   // Lane offset: misaligned low bits are dropped, which also covers the non-trap build.
   always_comb begin
      w_lo    = 2'b00;
      w_be    = 4'b1111;
      w_wdata = wdata;
      case (w_size)
         c_SZ_BYTE: begin
            w_lo    = addr[1:0];
            w_be    = 4'b0001 << addr[1:0];
            w_wdata = {4{wdata[7:0]}};
         end
         c_SZ_HALF: begin
            w_lo    = {addr[1], 1'b0};
            w_be    = 4'b0011 << {addr[1], 1'b0};
            w_wdata = {2{wdata[15:0]}};
         end
         default: ;
      endcase
   end

`ifdef MISALIGN_TRAP_EN
   logic r_mis;
   assign w_trap = ((w_size == c_SZ_HALF) && addr[0]) ||
                   ((w_size == c_SZ_WORD) && (addr[1:0] != 2'b00));
   assign misalign_err = done && r_mis;

   always_ff @(posedge clk) begin
      if (rst)
         r_mis <= 1'b0;
      else if (w_start)
         r_mis <= w_trap;
   end
`else
   assign w_trap       = 1'b0;
   assign misalign_err = 1'b0;
`endif

   assign w_shift = mem_rdata >> {r_lo, 3'b000};

   always_comb begin
      w_load = w_shift;
      case (r_size)
         c_SZ_BYTE: w_load = {{24{w_shift[7] & !r_uns}}, w_shift[7:0]};
         c_SZ_HALF: w_load = {{16{w_shift[15] & !r_uns}}, w_shift[15:0]};
         default:   ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_start) w_next = w_trap ? S_DONE : S_REQ;
         S_REQ:   if (mem_ack) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_be    <= 4'b0000;
         mem_wdata <= '0;
         rdata     <= '0;
         r_read    <= 1'b0;
         r_uns     <= 1'b0;
         r_size    <= c_SZ_WORD;
         r_lo      <= 2'b00;
      end else begin
         if (w_start && !w_trap) begin
            mem_req   <= 1'b1;
            mem_we    <= memWrite && !memRead;
            mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
            mem_be    <= w_be;
            mem_wdata <= w_wdata;
            r_read    <= memRead;
            r_uns     <= unsignedFlag;
            r_size    <= w_size;
            r_lo      <= w_lo;
         end else if (w_start && w_trap) begin
            rdata <= '0;
         end
         if ((r_state == S_REQ) && mem_ack) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'b0000;
            mem_wdata <= '0;
            if (r_read)
               rdata <= w_load;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Function : Scoreboard bench for load_store_unit (honours MISALIGN_TRAP_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        memRead = 1'b0;
   logic        memWrite = 1'b0;
   logic [2:0]  memOffset = 3'b100;
   logic        unsignedFlag = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic        stall;
   logic [31:0] rdata;
   logic        done;
   logic        misalign_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] model_rdata = '0;

`ifdef MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   typedef struct {
      logic [31:0] rdata;
      logic        mis;
      int          lat;
   } exp_t;
   exp_t sb[$];

   load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst), .memRead(memRead), .memWrite(memWrite),
      .memOffset(memOffset), .unsignedFlag(unsignedFlag), .addr(addr),
      .wdata(wdata), .stall(stall), .rdata(rdata), .done(done),
      .misalign_err(misalign_err), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One transaction: push expectation at start, check the bus each REQ cycle,
   // pop and compare when done appears (bounded wait).
   task automatic run_txn(input string name, input logic rd, input logic wr,
                          input logic [2:0] off, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int waits, input logic [31:0] mrd, input logic trap,
                          input logic [31:0] e_addr, input logic [3:0] e_be,
                          input logic [31:0] e_wd, input logic [31:0] e_load);
      exp_t e;
      exp_t got;
      int   lat;
      logic seen;
      @(posedge clk); #2;
      memRead = rd; memWrite = wr; memOffset = off; unsignedFlag = uns;
      addr = a; wdata = wd; mem_ack = 1'b0;
      e.lat   = trap ? 1 : waits + 2;
      e.mis   = trap;
      e.rdata = trap ? 32'h0 : (rd ? e_load : model_rdata);
      model_rdata = e.rdata;
      sb.push_back(e);
      #1;
      checks++;
      if (stall !== 1'b1) begin
         errors++;
         $display("FAIL %s start stall: got %b want 1", name, stall);
      end
      seen = 1'b0;
      lat  = 0;
      for (int i = 1; i <= 20 && !seen; i++) begin
         @(posedge clk); #2;
         memRead = 1'b0; memWrite = 1'b0; mem_ack = 1'b0;
         if (done === 1'b1) begin
            seen = 1'b1;
            lat  = i;
         end else if (!trap) begin
            checks++;
            if (mem_req !== 1'b1 || mem_we !== (wr & ~rd) || mem_addr !== e_addr ||
                mem_be !== e_be || stall !== 1'b1) begin
               errors++;
               $display("FAIL %s req cyc%0d: req=%b we=%b addr=%h be=%b stall=%b want req=1 we=%b addr=%h be=%b stall=1",
                        name, i, mem_req, mem_we, mem_addr, mem_be, stall, wr & ~rd, e_addr, e_be);
            end
            if (!rd) begin
               checks++;
               if (mem_wdata !== e_wd) begin
                  errors++;
                  $display("FAIL %s wdata: got %h want %h", name, mem_wdata, e_wd);
               end
            end
            if (i - 1 == waits) begin
               mem_ack   = 1'b1;
               mem_rdata = mrd;
            end
         end
      end
      got = sb.pop_front();
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s timeout: done not seen within 20 cycles", name);
      end else if (lat != got.lat || rdata !== got.rdata || misalign_err !== got.mis ||
                   stall !== 1'b0 || mem_req !== 1'b0) begin
         errors++;
         $display("FAIL %s done: lat=%0d rdata=%h mis=%b stall=%b req=%b want lat=%0d rdata=%h mis=%b stall=0 req=0",
                  name, lat, rdata, misalign_err, stall, mem_req, got.lat, got.rdata, got.mis);
      end
   endtask

   task automatic test_reset();
      memRead = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      checks++;
      if (stall !== 1'b0 || done !== 1'b0 || misalign_err !== 1'b0 || mem_req !== 1'b0 ||
          mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_be !== 4'h0 || mem_wdata !== 32'h0 ||
          rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset: stall=%b done=%b mis=%b req=%b we=%b addr=%h be=%b wd=%h rdata=%h want all 0",
                  stall, done, misalign_err, mem_req, mem_we, mem_addr, mem_be, mem_wdata, rdata);
      end
      memRead = 1'b0;
      @(posedge clk); #2;
      rst = 1'b0;
      model_rdata = 32'h0;
   endtask

   task automatic test_store();
      run_txn("sw", 1'b0, 1'b1, 3'b100, 1'b0, 32'h104, 32'hDEADBEEF, 0, 32'h0, 1'b0,
              32'h104, 4'b1111, 32'hDEADBEEF, 32'h0);
      run_txn("sb_wait", 1'b0, 1'b1, 3'b001, 1'b0, 32'h101, 32'h000000A5, 3, 32'h0, 1'b0,
              32'h100, 4'b0010, 32'hA5A5A5A5, 32'h0);
      run_txn("sh", 1'b0, 1'b1, 3'b010, 1'b0, 32'h106, 32'h1234ABCD, 1, 32'h0, 1'b0,
              32'h104, 4'b1100, 32'hABCDABCD, 32'h0);
   endtask

   task automatic test_load();
      run_txn("lb", 1'b1, 1'b0, 3'b001, 1'b0, 32'h203, 32'h0, 0, 32'h80112233, 1'b0,
              32'h200, 4'b1000, 32'h0, 32'hFFFFFF80);
      run_txn("lbu", 1'b1, 1'b0, 3'b001, 1'b1, 32'h203, 32'h0, 0, 32'h80112233, 1'b0,
              32'h200, 4'b1000, 32'h0, 32'h00000080);
      run_txn("lh", 1'b1, 1'b0, 3'b010, 1'b0, 32'h202, 32'h0, 2, 32'h9ABC0000, 1'b0,
              32'h200, 4'b1100, 32'h0, 32'hFFFF9ABC);
      run_txn("lhu", 1'b1, 1'b0, 3'b010, 1'b1, 32'h202, 32'h0, 0, 32'h9ABC0000, 1'b0,
              32'h200, 4'b1100, 32'h0, 32'h00009ABC);
      run_txn("lb_pos", 1'b1, 1'b0, 3'b001, 1'b0, 32'h301, 32'h0, 0, 32'h00007F00, 1'b0,
              32'h300, 4'b0010, 32'h0, 32'h0000007F);
      run_txn("rd_wr_both", 1'b1, 1'b1, 3'b111, 1'b0, 32'h108, 32'h55555555, 0, 32'hCAFEF00D, 1'b0,
              32'h108, 4'b1111, 32'h0, 32'hCAFEF00D);
   endtask

   task automatic test_misalign();
      run_txn("lw_mis", 1'b1, 1'b0, 3'b100, 1'b0, 32'h102, 32'h0, 0, 32'h11223344, TRAP,
              32'h100, 4'b1111, 32'h0, 32'h11223344);
      run_txn("sh_mis", 1'b0, 1'b1, 3'b010, 1'b0, 32'h103, 32'h0000BEEF, 0, 32'h0, TRAP,
              32'h100, 4'b1100, 32'hBEEFBEEF, 32'h0);
   endtask

   task automatic test_back_to_back();
      run_txn("b2b_lbu", 1'b1, 1'b0, 3'b001, 1'b1, 32'h402, 32'h0, 0, 32'hA1B2C3D4, 1'b0,
              32'h400, 4'b0100, 32'h0, 32'h000000B2);
      run_txn("b2b_sw", 1'b0, 1'b1, 3'b100, 1'b0, 32'h404, 32'h01020304, 0, 32'h0, 1'b0,
              32'h404, 4'b1111, 32'h01020304, 32'h0);
      run_txn("b2b_lh", 1'b1, 1'b0, 3'b010, 1'b0, 32'h400, 32'h0, 1, 32'h12348001, 1'b0,
              32'h400, 4'b0011, 32'h0, 32'hFFFF8001);
   endtask

   task automatic test_reset_mid_req();
      @(posedge clk); #2;
      memRead = 1'b1; memOffset = 3'b100; addr = 32'h300;
      @(posedge clk); #2;
      memRead = 1'b0;
      checks++;
      if (mem_req !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid req_before: got %b want 1", mem_req);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (stall !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid stall_in_rst: got %b want 0", stall);
      end
      @(posedge clk); #2;
      rst = 1'b0;
      model_rdata = 32'h0;
      checks++;
      if (mem_req !== 1'b0 || stall !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid after: req=%b stall=%b done=%b want 0 0 0", mem_req, stall, done);
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #2;
         checks++;
         if (done !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid idle%0d: done=%b req=%b want 0 0", i, done, mem_req);
         end
      end
      mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
      @(posedge clk); #2;
      mem_ack = 1'b0;
      checks++;
      if (done !== 1'b0 || rdata !== model_rdata) begin
         errors++;
         $display("FAIL stray_ack: done=%b rdata=%h want done=0 rdata=%h", done, rdata, model_rdata);
      end
   endtask

   initial begin
      test_reset();
      test_store();
      test_load();
      test_misalign();
      test_back_to_back();
      test_reset_mid_req();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_empty: %0d entries left want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
